// File: rtl/rc_pkt_crc.sv
// rc_pkt_crc: receive-side packet checker for the USB receive path.
// Takes the destuffed serial stream (LSB of every field first), captures the
// PID, classifies the packet, checks CRC5/CRC16 and length, and assembles the
// payload. The result is held with pkt_status=1 until pkt_rec.
module rc_pkt_crc #(
    parameter int MAX_BYTES = 8,
    parameter bit CHECK_CRC = 1'b1,
    localparam int LEN_W = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_in,
    input  logic                   s_valid,
    input  logic                   start_rc_crc,
    input  logic                   end_rc_crc,
    input  logic                   pkt_rec,
    output logic                   pkt_status,
    output logic [7:0]             rc_pid,
    output logic [1:0]             pkt_type,
    output logic [8*MAX_BYTES-1:0] rc_data,
    output logic [LEN_W-1:0]       rc_len,
    output logic                   crc_error,
    output logic                   pid_error,
    output logic                   len_error,
    output logic                   overrun
);

    localparam int DATA_W   = 8 * MAX_BYTES;
    // Largest legal data body: payload plus the 16-bit CRC field.
    localparam int BODY_MAX = 8 * (MAX_BYTES + 2);
    // Body counter saturates at BODY_MAX+1, which is enough to flag overlength.
    localparam int BC_W     = $clog2(BODY_MAX + 2);
    localparam int IDX_W    = $clog2(DATA_W);
    // Token body (addr/endp + CRC5) copied into the low payload bits.
    localparam int TOK_W    = (DATA_W < 16) ? DATA_W : 16;

    localparam logic [4:0]  CRC5_PRESET  = 5'h1F;
    localparam logic [4:0]  CRC5_GOOD    = 5'b01100;
    localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
    localparam logic [15:0] CRC16_GOOD   = 16'h800D;

    localparam logic [1:0] T_TOKEN = 2'b01;
    localparam logic [1:0] T_HAND  = 2'b10;
    localparam logic [1:0] T_DATA  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_BODY,
        S_DONE,
        S_HOLD
    } state_t;

    // One serial step of the USB CRC5 (x^5+x^2+1), MSB-feedback form.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    // One serial step of the USB CRC16 (x^16+x^15+x^2+1), MSB-feedback form.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          pid_sh_q, pid_sh_d;
    logic [3:0]          pid_cnt_q, pid_cnt_d;
    logic [BC_W-1:0]     body_cnt_q, body_cnt_d;
    logic [15:0]         dly_q, dly_d;
    logic [4:0]          crc5_q, crc5_d;
    logic [15:0]         crc16_q, crc16_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          rc_pid_q, rc_pid_d;
    logic [1:0]          pkt_type_q, pkt_type_d;
    logic [LEN_W-1:0]    rc_len_q, rc_len_d;
    logic                crc_err_q, crc_err_d;
    logic                pid_err_q, pid_err_d;
    logic                len_err_q, len_err_d;
    logic                status_q, status_d;
    logic                overrun_q, overrun_d;

    logic [BC_W-1:0]     body_minus;
    logic [IDX_W-1:0]    commit_idx;
    logic                pid_bad;
    logic                len_bad;
    logic                crc_bad;
    logic                data_len_ok;
    logic                start_take;

    // Payload bit index of the oldest bit in the delay line (body bit minus CRC16 depth).
    assign body_minus = body_cnt_q - BC_W'(16);
    assign commit_idx = body_minus[IDX_W-1:0];

    // Packet checks, evaluated from the accumulated state and consumed in DONE.
    always_comb begin
        pid_bad     = (pid_cnt_q != 4'd8)
                   || (pid_sh_q[7:4] != ~pid_sh_q[3:0])
                   || (pid_sh_q[1:0] == 2'b00);
        data_len_ok = (body_cnt_q[2:0] == 3'd0)
                   && (body_cnt_q >= BC_W'(16))
                   && (body_cnt_q <= BC_W'(BODY_MAX));
        len_bad     = 1'b0;
        crc_bad     = 1'b0;
        unique case (pid_sh_q[1:0])
            T_HAND:  len_bad = (body_cnt_q != '0);
            T_TOKEN: begin
                len_bad = (body_cnt_q != BC_W'(16));
                crc_bad = (crc5_q != CRC5_GOOD);
            end
            T_DATA:  begin
                len_bad = !data_len_ok;
                crc_bad = (crc16_q != CRC16_GOOD);
            end
            default: begin
                len_bad = 1'b0;
                crc_bad = 1'b0;
            end
        endcase
    end

    // Next-state logic: FSM, bit capture, LFSRs, payload commit and result registers.
    always_comb begin
        state_d    = state_q;
        pid_sh_d   = pid_sh_q;
        pid_cnt_d  = pid_cnt_q;
        body_cnt_d = body_cnt_q;
        dly_d      = dly_q;
        crc5_d     = crc5_q;
        crc16_d    = crc16_q;
        data_d     = data_q;
        rc_pid_d   = rc_pid_q;
        pkt_type_d = pkt_type_q;
        rc_len_d   = rc_len_q;
        crc_err_d  = crc_err_q;
        pid_err_d  = pid_err_q;
        len_err_d  = len_err_q;
        status_d   = status_q;
        overrun_d  = 1'b0;
        start_take = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (s_valid && start_rc_crc) begin
                    start_take = 1'b1;
                end
            end

            S_PID: begin
                if (s_valid) begin
                    pid_sh_d[pid_cnt_q[2:0]] = s_in;
                    pid_cnt_d = pid_cnt_q + 4'd1;
                    if (end_rc_crc) begin
                        state_d = S_DONE;
                    end else if (pid_cnt_q == 4'd7) begin
                        state_d = S_BODY;
                    end
                end
            end

            S_BODY: begin
                if (s_valid) begin
                    if (start_rc_crc) begin
                        // New packet mid-body: drop the current one and resync.
                        start_take = 1'b1;
                    end else begin
                        crc5_d  = crc5_step(crc5_q, s_in);
                        crc16_d = crc16_step(crc16_q, s_in);
                        dly_d   = {s_in, dly_q[15:1]};
                        // The bit leaving the delay line has 16 later bits behind it,
                        // so it cannot be part of the CRC16 field.
                        if (body_cnt_q >= BC_W'(16) && body_cnt_q < BC_W'(BODY_MAX)) begin
                            data_d[commit_idx] = dly_q[0];
                        end
                        if (body_cnt_q <= BC_W'(BODY_MAX)) begin
                            body_cnt_d = body_cnt_q + BC_W'(1);
                        end
                        if (end_rc_crc) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                rc_pid_d   = pid_sh_q;
                pkt_type_d = pid_sh_q[1:0];
                pid_err_d  = pid_bad;
                len_err_d  = !pid_bad && len_bad;
                crc_err_d  = CHECK_CRC && !pid_bad && !len_bad && crc_bad;
                rc_len_d   = '0;
                if (!pid_bad) begin
                    if (pid_sh_q[1:0] == T_TOKEN) begin
                        rc_len_d = LEN_W'(2);
                    end else if (pid_sh_q[1:0] == T_DATA && body_cnt_q >= BC_W'(16)) begin
                        rc_len_d = LEN_W'(body_minus >> 3);
                    end
                end
                // Tokens never reach the commit path; their whole body is still in the delay line.
                if (!pid_bad && pid_sh_q[1:0] == T_TOKEN && body_cnt_q == BC_W'(16)) begin
                    data_d[TOK_W-1:0] = dly_q[TOK_W-1:0];
                end
                state_d = S_HOLD;
            end

            S_HOLD: begin
                // First HOLD cycle raises pkt_status; acknowledge only counts once it is visible.
                if (!status_q) begin
                    status_d = 1'b1;
                end else if (pkt_rec) begin
                    status_d = 1'b0;
                    state_d  = S_IDLE;
                end
                if (s_valid && start_rc_crc) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared packet-start initialisation; the start bit is PID bit 0.
        if (start_take) begin
            pid_sh_d   = {7'd0, s_in};
            pid_cnt_d  = 4'd1;
            body_cnt_d = '0;
            dly_d      = '0;
            crc5_d     = CRC5_PRESET;
            crc16_d    = CRC16_PRESET;
            data_d     = '0;
            crc_err_d  = 1'b0;
            pid_err_d  = 1'b0;
            len_err_d  = 1'b0;
            state_d    = end_rc_crc ? S_DONE : S_PID;
        end
    end

    // State registers with synchronous reset; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pid_sh_q   <= '0;
            pid_cnt_q  <= '0;
            body_cnt_q <= '0;
            dly_q      <= '0;
            crc5_q     <= CRC5_PRESET;
            crc16_q    <= CRC16_PRESET;
            data_q     <= '0;
            rc_pid_q   <= '0;
            pkt_type_q <= '0;
            rc_len_q   <= '0;
            crc_err_q  <= 1'b0;
            pid_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            status_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_sh_q   <= pid_sh_d;
            pid_cnt_q  <= pid_cnt_d;
            body_cnt_q <= body_cnt_d;
            dly_q      <= dly_d;
            crc5_q     <= crc5_d;
            crc16_q    <= crc16_d;
            data_q     <= data_d;
            rc_pid_q   <= rc_pid_d;
            pkt_type_q <= pkt_type_d;
            rc_len_q   <= rc_len_d;
            crc_err_q  <= crc_err_d;
            pid_err_q  <= pid_err_d;
            len_err_q  <= len_err_d;
            status_q   <= status_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pkt_status = status_q;
    assign rc_pid     = rc_pid_q;
    assign pkt_type   = pkt_type_q;
    assign rc_data    = data_q;
    assign rc_len     = rc_len_q;
    assign crc_error  = crc_err_q;
    assign pid_error  = pid_err_q;
    assign len_error  = len_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_rc_pkt_crc.sv
// Bench for rc_pkt_crc: directed packets, expected results queued by the driver
// and checked by an independent monitor when pkt_status rises.
`timescale 1ns/1ps
module tb_rc_pkt_crc;

    localparam int MAXB = 8;
    localparam int DW   = 8 * MAXB;
    localparam int LW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_in;
    logic          s_valid;
    logic          start_rc_crc;
    logic          end_rc_crc;
    logic          pkt_rec;
    logic          pkt_status;
    logic [7:0]    rc_pid;
    logic [1:0]    pkt_type;
    logic [DW-1:0] rc_data;
    logic [LW-1:0] rc_len;
    logic          crc_error;
    logic          pid_error;
    logic          len_error;
    logic          overrun;

    rc_pkt_crc #(.MAX_BYTES(MAXB), .CHECK_CRC(1'b1)) dut (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid),
        .start_rc_crc(start_rc_crc), .end_rc_crc(end_rc_crc), .pkt_rec(pkt_rec),
        .pkt_status(pkt_status), .rc_pid(rc_pid), .pkt_type(pkt_type),
        .rc_data(rc_data), .rc_len(rc_len), .crc_error(crc_error),
        .pid_error(pid_error), .len_error(len_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          tid;
        logic [7:0]  pid;
        logic [1:0]  ptype;
        logic [3:0]  len;
        logic [63:0] data;
        logic [63:0] mask;
        bit          chk_hdr;
        bit          chk_len;
        logic        crc_e;
        logic        pid_e;
        logic        len_e;
        int          end_edge;
    } exp_t;

    exp_t        exp_q[$];
    bit          pkt_q[$];
    logic [15:0] run_crc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int tid, input logic [7:0] pid, input logic [1:0] pt,
                                input logic [3:0] len, input logic [63:0] data,
                                input logic [63:0] mask, input bit hdr, input bit cl,
                                input logic ce, input logic pe, input logic le);
        exp_t e;
        e.tid = tid; e.pid = pid; e.ptype = pt; e.len = len; e.data = data; e.mask = mask;
        e.chk_hdr = hdr; e.chk_len = cl; e.crc_e = ce; e.pid_e = pe; e.len_e = le;
        e.end_edge = 0;
        return e;
    endfunction

    // Field bits go out LSB first.
    task automatic push_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) pkt_q.push_back(v[i]);
    endtask

    // Payload byte, also folded into a reflected (LSB-first, 0xA001) CRC16 generator.
    task automatic push_dbyte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            bit x;
            x = b[i];
            pkt_q.push_back(x);
            if (run_crc[0] ^ x) run_crc = (run_crc >> 1) ^ 16'hA001;
            else                run_crc = run_crc >> 1;
        end
    endtask

    task automatic push_crc16();
        push_bits(~run_crc, 16);
    endtask

    // Serialise pkt_q. Optional stuffing gaps after every 6th bit carry a bogus
    // start and random data with s_valid low, which the DUT must ignore.
    task automatic send_pkt(input exp_t e, input bit gaps, input bit with_end);
        int n;
        exp_t ee;
        ee = e;
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_in         = pkt_q[i];
            s_valid      = 1'b1;
            start_rc_crc = (i == 0);
            end_rc_crc   = with_end && (i == n - 1);
            if (with_end && i == n - 1) begin
                ee.end_edge = cyc + 1;
                exp_q.push_back(ee);
            end
            if (gaps && ((i + 1) % 6 == 0) && (i != n - 1)) begin
                @(negedge clk);
                s_valid      = 1'b0;
                s_in         = 1'($urandom);
                start_rc_crc = 1'b1;
                end_rc_crc   = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b0; start_rc_crc = 1'b0; end_rc_crc = 1'b0; s_in = 1'b0;
        pkt_q.delete();
    endtask

    task automatic wait_status(input string nm);
        for (int i = 0; i < 40 && pkt_status !== 1'b1; i++) @(negedge clk);
        if (pkt_status !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=pkt_status_low required=pkt_status_high", nm);
        end
    endtask

    task automatic ack(input string nm);
        @(negedge clk);
        pkt_rec = 1'b1;
        @(negedge clk);
        pkt_rec = 1'b0;
        chk({nm, "_status_fall"}, 64'(pkt_status), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_status"}, 64'(pkt_status), 64'd0);
        chk({nm, "_pid"},    64'(rc_pid),     64'd0);
        chk({nm, "_type"},   64'(pkt_type),   64'd0);
        chk({nm, "_data"},   64'(rc_data),    64'd0);
        chk({nm, "_len"},    64'(rc_len),     64'd0);
        chk({nm, "_flags"},  64'({crc_error, pid_error, len_error, overrun}), 64'd0);
    endtask

    // Monitor: on each rising pkt_status pop the oldest expectation and compare.
    logic st_prev = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (pkt_status === 1'b1 && st_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=pkt_status_high required=no_result");
            end else begin
                me = exp_q.pop_front();
                chk($sformatf("t%0d_latency", me.tid), 64'(cyc - me.end_edge), 64'd2);
                if (me.chk_hdr) begin
                    chk($sformatf("t%0d_pid", me.tid),  64'(rc_pid),   64'(me.pid));
                    chk($sformatf("t%0d_type", me.tid), 64'(pkt_type), 64'(me.ptype));
                end
                if (me.chk_len)
                    chk($sformatf("t%0d_len", me.tid), 64'(rc_len), 64'(me.len));
                if (me.mask != 64'd0)
                    chk($sformatf("t%0d_data", me.tid), rc_data & me.mask, me.data & me.mask);
                chk($sformatf("t%0d_crc_error", me.tid), 64'(crc_error), 64'(me.crc_e));
                chk($sformatf("t%0d_pid_error", me.tid), 64'(pid_error), 64'(me.pid_e));
                chk($sformatf("t%0d_len_error", me.tid), 64'(len_error), 64'(me.len_e));
                $display("pkt t%0d pid=%02h type=%0d len=%0d data=%016h crc_e=%0b pid_e=%0b len_e=%0b",
                         me.tid, rc_pid, pkt_type, rc_len, rc_data, crc_error, pid_error, len_error);
            end
        end
        st_prev <= pkt_status;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; s_in = 1'b0; s_valid = 1'b0; start_rc_crc = 1'b0;
        end_rc_crc = 1'b0; pkt_rec = 1'b0; run_crc = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // t1: ACK handshake
        push_bits(16'h00D2, 8);
        e = mk(1, 8'hD2, 2'b10, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0);
        send_pkt(e, 0, 1);
        wait_status("t1");
        ack("t1");

        // t2: SETUP addr 0 endp 0, CRC5 field 00010
        push_bits(16'h002D, 8); push_bits(16'h0000, 11); push_bits(16'h0002, 5);
        e = mk(2, 8'h2D, 2'b01, 4'd2, 64'd0, 64'h7FF, 1, 1, 0, 0, 0);
        send_pkt(e, 0, 1);
        wait_status("t2");
        ack("t2");

        // t3: same token with address bit 0 flipped
        push_bits(16'h002D, 8); push_bits(16'h0001, 11); push_bits(16'h0002, 5);
        e = mk(3, 8'h2D, 2'b01, 4'd2, 64'd1, 64'h7FF, 1, 1, 1, 0, 0);
        send_pkt(e, 0, 1);
        wait_status("t3");
        ack("t3");

        // t4: DATA0 bytes 01..08 with stuffing gaps
        push_bits(16'h00C3, 8);
        run_crc = 16'hFFFF;
        for (int k = 1; k <= 8; k++) push_dbyte(8'(k));
        push_crc16();
        e = mk(4, 8'hC3, 2'b11, 4'd8, 64'h0807060504030201, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0);
        send_pkt(e, 1, 1);
        wait_status("t4");
        ack("t4");

        // t5: DATA1 zero-length, CRC field 0000
        push_bits(16'h004B, 8); push_bits(16'h0000, 16);
        e = mk(5, 8'h4B, 2'b11, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0);
        send_pkt(e, 0, 1);
        wait_status("t5");
        ack("t5");

        // t6: DATA1 with a 12-bit body
        push_bits(16'h004B, 8); push_bits(16'h0ABC, 12);
        e = mk(6, 8'h4B, 2'b11, 4'd0, 64'd0, 64'd0, 1, 0, 0, 0, 1);
        send_pkt(e, 0, 1);
        wait_status("t6");
        ack("t6");

        // t7: DATA0 with 9 payload bytes; only the first 8 fit
        push_bits(16'h00C3, 8);
        run_crc = 16'hFFFF;
        for (int k = 0; k < 9; k++) push_dbyte(8'(8'h11 + k));
        push_crc16();
        e = mk(7, 8'hC3, 2'b11, 4'd0, 64'h1817161514131211, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 1);
        send_pkt(e, 0, 1);
        wait_status("t7");
        ack("t7");

        // t8: corrupt PID, then a start while the result is held
        push_bits(16'h00C4, 8);
        e = mk(8, 8'hC4, 2'b00, 4'd0, 64'd0, 64'd0, 1, 0, 0, 1, 0);
        send_pkt(e, 0, 1);
        wait_status("t8");
        @(negedge clk);
        s_valid = 1'b1; start_rc_crc = 1'b1; s_in = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; start_rc_crc = 1'b0; s_in = 1'b0;
        chk("t8_overrun_pulse", 64'(overrun), 64'd1);
        chk("t8_hold_status", 64'(pkt_status), 64'd1);
        chk("t8_hold_pid", 64'(rc_pid), 64'hC4);
        @(negedge clk);
        chk("t8_overrun_end", 64'(overrun), 64'd0);
        chk("t8_hold_pid_err", 64'(pid_error), 64'd1);
        chk("t8_hold_pid2", 64'(rc_pid), 64'hC4);
        ack("t8");

        // t9: start and end on the same bit
        pkt_q.push_back(1'b1);
        e = mk(9, 8'h00, 2'b00, 4'd0, 64'd0, 64'd0, 0, 0, 0, 1, 0);
        send_pkt(e, 0, 1);
        wait_status("t9");
        ack("t9");

        // t10: reset in the middle of a data body
        push_bits(16'h00C3, 8);
        run_crc = 16'hFFFF;
        push_dbyte(8'hAA); push_dbyte(8'hBB); push_dbyte(8'hCC);
        e = mk(10, 8'h00, 2'b00, 4'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0);
        send_pkt(e, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("t10_rst");
        @(negedge clk);
        chk("t10_idle_status", 64'(pkt_status), 64'd0);

        // t11: clean ACK after the reset
        push_bits(16'h00D2, 8);
        e = mk(11, 8'hD2, 2'b10, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0);
        send_pkt(e, 0, 1);
        wait_status("t11");
        ack("t11");

        repeat (5) @(negedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc_pkt_crc.md
Name: rc_pkt_crc

Overview:
- Parametrised successor to the receive-side CRC stage, placed after the bit-stream decoder in the USB receive path: NRZI decode, then bit unstuffing, then bit-stream decode, then this block.
- Accepts a serial bit stream with a per-bit valid, decodes and checks the PID, and classifies the packet as token, data or handshake.
- Checks CRC5 on token packets and CRC16 on data packets, and assembles a variable-length payload of up to MAX_BYTES bytes.
- Holds the result with pkt_status = RECEIVED until the consumer acknowledges with pkt_rec.

Parameters:
- MAX_BYTES, 8, maximum data-packet payload in bytes (1..1024). rc_data width is 8*MAX_BYTES.
- CHECK_CRC, 1, 1 = CRC residual compared; 0 = crc_error forced to 0 (bypass for bring-up).
- LEN_W, $clog2(MAX_BYTES+1), width of rc_len (localparam, not overridable).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_in  in  1  serial bit from decoder, USB wire order (LSB of each field first)
- s_valid  in  1  s_in carries a real bit this cycle (low on cycles where a stuffed bit was removed)
- start_rc_crc  in  1  pulse coincident with the first valid bit of the packet
- end_rc_crc  in  1  pulse coincident with the last valid bit of the packet
- pkt_rec  in  1  consumer acknowledge; releases the held result
- pkt_status  out  1  0 = PROCESSING, 1 = RECEIVED (result valid)
- rc_pid  out  8  received PID byte
- pkt_type  out  2  01 token, 11 data, 10 handshake (copy of PID[1:0])
- rc_data  out  8*MAX_BYTES  payload; byte k at [8k+7:8k], bit 0 = first received bit; unused bytes 0
- rc_len  out  LEN_W  payload byte count (token: 2; handshake: 0)
- crc_error  out  1  CRC residual mismatch
- pid_error  out  1  PID[7:4] != ~PID[3:0], or PID[1:0] == 00
- len_error  out  1  illegal body length for the packet type
- overrun  out  1  one-cycle pulse: start_rc_crc arrived while in HOLD

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSRs preset. Reset mid-packet aborts immediately; no result is produced.
- Only cycles with s_valid=1 advance counters, shift registers and LFSRs. start and end are honoured only when s_valid=1.
- FSM states and transitions:
  - IDLE: start moves to PID. The start bit is counted as PID bit 0, and the PID registers and error flags are cleared.
  - PID: shift bits until 8 have been received, then move to BODY. If end arrives with 8 or fewer bits, move to DONE.
  - BODY: shift body bits until end, then move to DONE. If a new start arrives, restart: discard the packet and go to PID.
  - DONE: one cycle. Evaluate all checks and register outputs, then move to HOLD.
  - HOLD: pkt_status=1, outputs stable. pkt_rec moves to IDLE, with pkt_status=0 on the next cycle. A start in HOLD is ignored and pulses overrun.
- Latency: pkt_status rises 2 cycles after the clock edge that samples end_rc_crc.
- PID checks:
  - pid_error is asserted if PID[7:4] != ~PID[3:0], or the packet is shorter than 8 bits, or PID[1:0]==00.
  - When pid_error=1, crc_error=0 and len_error=0.
- Body length rules (B = valid body bits after the PID):
  - Handshake: B must be 0.
  - Token: B must be 16. rc_data[10:0] = addr/endp, rc_len = 2.
  - Data: B must be a multiple of 8, with 16 <= B <= 8*(MAX_BYTES+2). rc_len = B/8 - 2.
  - Any violation sets len_error. When len_error=1, crc_error=0.
- Payload storage:
  - Payload bytes are written until MAX_BYTES bytes have been stored; further body bits are not stored, but CRC continues.
  - The final 16 bits (the CRC16 field) are never stored: hold a 16-bit delay line and commit a byte only once 16 later bits exist.
- CRC5:
  - Polynomial x^5+x^2+1, preset 5'b11111, run over all 16 body bits.
  - Good residual is 5'b01100.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, preset 16'hFFFF, run over all body bits including the CRC field.
  - Good residual is 16'h800D.
- Simultaneous start and end in IDLE: 1-bit packet, giving pid_error=1.
- pkt_rec in any state other than HOLD: ignored.

Test Plan:
- Handshake ACK, PID 8'hD2, 8 bits, no body -> pkt_status=1 two cycles after end; rc_pid=8'hD2, pkt_type=10, rc_len=0, all error flags 0. pkt_rec -> pkt_status=0 next cycle.
- SETUP token, PID 8'h2D, addr=0, endp=0, CRC5=5'b00010 -> pkt_type=01, rc_len=2, rc_data[10:0]=0, crc_error=0. Flip one address bit -> crc_error=1.
- DATA0, PID 8'hC3, 8 payload bytes 8'h01..8'h08 plus correct CRC16, with s_valid dropped for 1 cycle after every 6th bit (stuffing gaps) -> rc_len=8, byte k = k+1, crc_error=0.
- DATA1, PID 8'h4B, zero-length payload with CRC field 16'h0000 -> rc_len=0, crc_error=0. 12-bit body -> len_error=1, crc_error=0.
- With MAX_BYTES=8, a 9-byte DATA0 -> len_error=1 and bytes 0..7 stored. Corrupt PID 8'hC4 -> pid_error=1, other flags 0.
- start asserted in HOLD -> overrun pulses for 1 cycle, held outputs unchanged. rst asserted mid-body -> next cycle all outputs 0, FSM in IDLE, and a following clean ACK is received correctly.
